// File: rtl/vc_pkg.sv
// Shared defaults and index types for the victim cache tag/LRU slice.
package vc_pkg;

    localparam int DEF_WAYS     = 4;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_OFFSET_W = 5;
    localparam int DEF_IDX_W    = $clog2(DEF_WAYS);

    typedef logic [DEF_IDX_W-1:0] age_t;
    typedef logic [DEF_IDX_W-1:0] way_idx_t;

endpackage

// File: rtl/victim_cache_lru.sv
// Age-based true-LRU tracker: ages stay a permutation, 0 = MRU, WAYS-1 = LRU.
module victim_cache_lru
    import vc_pkg::*;
#(
    parameter int WAYS = DEF_WAYS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    lk_touch,
    input  logic                    lk_demote,
    input  logic [$clog2(WAYS)-1:0] lk_way,
    input  logic                    ins_touch,
    input  logic [$clog2(WAYS)-1:0] ins_way,
    output logic [$clog2(WAYS)-1:0] lru_way
);

    localparam int IDX_W = $clog2(WAYS);

    logic [WAYS-1:0][IDX_W-1:0] age;
    logic [WAYS-1:0][IDX_W-1:0] age_mid;
    logic [WAYS-1:0][IDX_W-1:0] age_next;

    // The lookup update is applied first and the insert touch on top of it, so the insert wins.
    always_comb begin
        age_mid = age;
        if (lk_touch) begin
            for (int i = 0; i < WAYS; i++) begin
                if (IDX_W'(i) == lk_way) begin
                    age_mid[i] = '0;
                end else if (age[i] < age[lk_way]) begin
                    age_mid[i] = age[i] + IDX_W'(1);
                end
            end
        end else if (lk_demote) begin
            for (int i = 0; i < WAYS; i++) begin
                if (IDX_W'(i) == lk_way) begin
                    age_mid[i] = IDX_W'(WAYS - 1);
                end else if (age[i] > age[lk_way]) begin
                    age_mid[i] = age[i] - IDX_W'(1);
                end
            end
        end

        age_next = age_mid;
        if (ins_touch) begin
            for (int i = 0; i < WAYS; i++) begin
                if (IDX_W'(i) == ins_way) begin
                    age_next[i] = '0;
                end else if (age_mid[i] < age_mid[ins_way]) begin
                    age_next[i] = age_mid[i] + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        lru_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age[i] == IDX_W'(WAYS - 1)) begin
                lru_way = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WAYS; i++) begin
                age[i] <= IDX_W'(i);
            end
        end else begin
            age <= age_next;
        end
    end

endmodule

// File: rtl/victim_cache_tag_lru.sv
// Fully-associative victim cache tag store with lookup/swap, insert/evict and LRU replacement.
module victim_cache_tag_lru
    import vc_pkg::*;
#(
    parameter int WAYS     = DEF_WAYS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int OFFSET_W = DEF_OFFSET_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         lookup_req,
    input  logic [ADDR_W-1:0]            lookup_addr,
    input  logic                         lookup_swap,
    output logic                         hit_valid,
    output logic                         hit,
    output logic [WAYS-1:0]              hit_way,
    input  logic                         ins_req,
    input  logic [ADDR_W-1:0]            ins_addr,
    input  logic                         ins_dirty,
    output logic                         ins_done,
    output logic [WAYS-1:0]              ins_way,
    output logic                         evict_valid,
    output logic [ADDR_W-OFFSET_W-1:0]   evict_tag,
    output logic                         evict_dirty,
    output logic [$clog2(WAYS+1)-1:0]    occupancy
);

    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int IDX_W = $clog2(WAYS);
    localparam int OCC_W = $clog2(WAYS + 1);

    logic [WAYS-1:0]             valid_q, valid_d;
    logic [WAYS-1:0]             dirty_q, dirty_d;
    logic [WAYS-1:0][TAG_W-1:0]  tag_q, tag_d;

    logic [TAG_W-1:0] lk_tag, ins_tag;
    logic             lk_hit, ins_hit, has_inv, lk_apply;
    logic [IDX_W-1:0] lk_idx, ins_idx, inv_idx, tgt_idx, lru_way;
    logic             unused_offsets;

    assign lk_tag         = lookup_addr[ADDR_W-1:OFFSET_W];
    assign ins_tag        = ins_addr[ADDR_W-1:OFFSET_W];
    assign unused_offsets = ^{lookup_addr[OFFSET_W-1:0], ins_addr[OFFSET_W-1:0]};

    function automatic logic [OCC_W-1:0] count_valid(input logic [WAYS-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WAYS; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        lk_hit  = 1'b0;
        lk_idx  = '0;
        ins_hit = 1'b0;
        ins_idx = '0;
        has_inv = 1'b0;
        inv_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == lk_tag) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == ins_tag) begin
                ins_hit = 1'b1;
                ins_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                has_inv = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
    end

    assign tgt_idx  = ins_hit ? ins_idx : (has_inv ? inv_idx : lru_way);
    assign lk_apply = lookup_req && lk_hit && !(ins_req && tgt_idx == lk_idx);

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        if (lk_apply && lookup_swap) begin
            valid_d[lk_idx] = 1'b0;
            dirty_d[lk_idx] = 1'b0;
        end
        if (ins_req) begin
            valid_d[tgt_idx] = 1'b1;
            tag_d[tgt_idx]   = ins_tag;
            dirty_d[tgt_idx] = ins_hit ? (dirty_q[tgt_idx] | ins_dirty) : ins_dirty;
        end
    end

    victim_cache_lru #(
        .WAYS (WAYS)
    ) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .lk_touch  (lk_apply && !lookup_swap),
        .lk_demote (lk_apply && lookup_swap),
        .lk_way    (lk_idx),
        .ins_touch (ins_req),
        .ins_way   (tgt_idx),
        .lru_way   (lru_way)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            tag_q       <= '0;
            hit_valid   <= 1'b0;
            hit         <= 1'b0;
            hit_way     <= '0;
            ins_done    <= 1'b0;
            ins_way     <= '0;
            evict_valid <= 1'b0;
            evict_tag   <= '0;
            evict_dirty <= 1'b0;
            occupancy   <= '0;
        end else begin
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            tag_q     <= tag_d;
            occupancy <= count_valid(valid_d);
            hit_valid <= lookup_req;
            ins_done  <= ins_req;
            if (lookup_req) begin
                hit     <= lk_hit;
                hit_way <= lk_hit ? (WAYS'(1) << lk_idx) : '0;
            end
            // Eviction reports what the target held before this insert overwrote it.
            if (ins_req) begin
                ins_way     <= WAYS'(1) << tgt_idx;
                evict_valid <= !ins_hit && valid_q[tgt_idx];
                evict_tag   <= tag_q[tgt_idx];
                evict_dirty <= dirty_q[tgt_idx];
            end
        end
    end

endmodule

// File: tb/tb_victim_cache_tag_lru.sv
// Randomized and directed bench for victim_cache_tag_lru against a recency-list reference model.
module tb_victim_cache_tag_lru;

    localparam int WAYS = 4;

    logic        clk;
    logic        rst_n;
    logic        lookup_req;
    logic [31:0] lookup_addr;
    logic        lookup_swap;
    logic        hit_valid;
    logic        hit;
    logic [3:0]  hit_way;
    logic        ins_req;
    logic [31:0] ins_addr;
    logic        ins_dirty;
    logic        ins_done;
    logic [3:0]  ins_way;
    logic        evict_valid;
    logic [26:0] evict_tag;
    logic        evict_dirty;
    logic [2:0]  occupancy;

    int tests_run = 0;
    int tests_failed = 0;

    victim_cache_tag_lru dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_req  (lookup_req),
        .lookup_addr (lookup_addr),
        .lookup_swap (lookup_swap),
        .hit_valid   (hit_valid),
        .hit         (hit),
        .hit_way     (hit_way),
        .ins_req     (ins_req),
        .ins_addr    (ins_addr),
        .ins_dirty   (ins_dirty),
        .ins_done    (ins_done),
        .ins_way     (ins_way),
        .evict_valid (evict_valid),
        .evict_tag   (evict_tag),
        .evict_dirty (evict_dirty),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: per-way contents plus a recency list of way numbers, most recent first.
    bit          m_valid [WAYS];
    bit          m_dirty [WAYS];
    int unsigned m_tag   [WAYS];
    int          m_rec[$];

    bit          e_hit_valid, e_hit, e_ins_done, e_ev_valid, e_ev_dirty;
    int unsigned e_hit_way, e_ins_way, e_ev_tag, e_occ;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        m_rec.delete();
        for (int i = 0; i < WAYS; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i]   = 0;
            m_rec.push_back(i);
        end
        e_hit_valid = 0; e_hit = 0; e_hit_way = 0;
        e_ins_done = 0; e_ins_way = 0;
        e_ev_valid = 0; e_ev_tag = 0; e_ev_dirty = 0;
        e_occ = 0;
    endfunction

    function automatic void moveWay(input int w, input bit to_front);
        for (int k = 0; k < m_rec.size(); k++) begin
            if (m_rec[k] == w) begin
                m_rec.delete(k);
                break;
            end
        end
        if (to_front) m_rec.push_front(w);
        else          m_rec.push_back(w);
    endfunction

    function automatic int findTag(input int unsigned t);
        for (int i = 0; i < WAYS; i++) begin
            if (m_valid[i] && m_tag[i] == t) return i;
        end
        return -1;
    endfunction

    function automatic void modelStep(input bit lr, input logic [31:0] la, input bit sw,
                                      input bit ir, input logic [31:0] ia, input bit id);
        int unsigned lt, it;
        int lw, mw, tgt;
        lt = la >> 5;
        it = ia >> 5;
        lw = lr ? findTag(lt) : -1;
        mw = -1;
        tgt = -1;
        if (ir) begin
            mw = findTag(it);
            if (mw >= 0) tgt = mw;
            else begin
                for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[i]) tgt = i;
                if (tgt < 0) tgt = m_rec[m_rec.size() - 1];
            end
        end
        e_hit_valid = lr;
        if (lr) begin
            e_hit     = (lw >= 0);
            e_hit_way = (lw >= 0) ? (1 << lw) : 0;
        end
        e_ins_done = ir;
        if (ir) begin
            e_ins_way  = 1 << tgt;
            e_ev_valid = (mw < 0) && m_valid[tgt];
            e_ev_tag   = m_tag[tgt];
            e_ev_dirty = m_dirty[tgt];
        end
        if (lw >= 0 && !(ir && tgt == lw)) begin
            if (sw) begin
                m_valid[lw] = 0;
                m_dirty[lw] = 0;
                moveWay(lw, 0);
            end else begin
                moveWay(lw, 1);
            end
        end
        if (ir) begin
            m_dirty[tgt] = (mw >= 0) ? (m_dirty[tgt] | id) : id;
            m_valid[tgt] = 1;
            m_tag[tgt]   = it;
            moveWay(tgt, 1);
        end
        e_occ = 0;
        for (int i = 0; i < WAYS; i++) e_occ += m_valid[i];
    endfunction

    task automatic compareAll();
        checkOutput("hit_valid",   hit_valid,   e_hit_valid);
        checkOutput("hit",         hit,         e_hit);
        checkOutput("hit_way",     hit_way,     e_hit_way);
        checkOutput("ins_done",    ins_done,    e_ins_done);
        checkOutput("ins_way",     ins_way,     e_ins_way);
        checkOutput("evict_valid", evict_valid, e_ev_valid);
        checkOutput("evict_tag",   evict_tag,   e_ev_tag);
        checkOutput("evict_dirty", evict_dirty, e_ev_dirty);
        checkOutput("occupancy",   occupancy,   e_occ);
    endtask

    // Called just after a falling edge; drives one cycle of requests and checks the registered results.
    task automatic applyStimulus(input bit lr, input logic [31:0] la, input bit sw,
                                 input bit ir, input logic [31:0] ia, input bit id);
        lookup_req  = lr;
        lookup_addr = la;
        lookup_swap = sw;
        ins_req     = ir;
        ins_addr    = ia;
        ins_dirty   = id;
        modelStep(lr, la, sw, ir, ia, id);
        @(negedge clk);
        lookup_req = 1'b0;
        ins_req    = 1'b0;
        compareAll();
    endtask

    task automatic insertTag(input int unsigned t, input bit d);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'(t) << 5, d);
    endtask

    task automatic lookupTag(input int unsigned t, input bit sw);
        applyStimulus(1'b1, (32'(t) << 5) | 32'h3, sw, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        lookup_req = 1'b0; lookup_addr = '0; lookup_swap = 1'b0;
        ins_req = 1'b0; ins_addr = '0; ins_dirty = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        compareAll();
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 4; t++) begin
            insertTag(32'h10 + t, t[0]);
            checkOutput("fill_way", ins_way, 32'(1) << t);
            checkOutput("fill_no_evict", evict_valid, 0);
        end
        checkOutput("fill_occ", occupancy, 4);

        insertTag(32'h14, 1'b0);
        checkOutput("full_way", ins_way, 4'b0001);
        checkOutput("full_evict", evict_valid, 1);
        checkOutput("full_evict_tag", evict_tag, 32'h10);

        lookupTag(32'h11, 1'b0);
        checkOutput("lk11_way", hit_way, 4'b0010);
        insertTag(32'h15, 1'b1);
        checkOutput("ins15_way", ins_way, 4'b0100);
        checkOutput("ins15_evict_tag", evict_tag, 32'h12);

        lookupTag(32'h13, 1'b1);
        checkOutput("swap13_hit", hit, 1);
        checkOutput("swap13_occ", occupancy, 3);
        insertTag(32'h16, 1'b0);
        checkOutput("ins16_way", ins_way, 4'b1000);
        checkOutput("ins16_no_evict", evict_valid, 0);

        applyStimulus(1'b1, 32'h14 << 5, 1'b1, 1'b1, 32'h17 << 5, 1'b0);
        checkOutput("same_hit", hit, 1);
        checkOutput("same_hit_way", hit_way, 4'b0001);
        checkOutput("same_ins_way", ins_way, 4'b0001);
        lookupTag(32'h17, 1'b0);
        checkOutput("same_17_valid", hit_way, 4'b0001);

        ins_req  = 1'b1;
        ins_addr = 32'h18 << 5;
        #2 rst_n = 1'b0;
        @(negedge clk);
        ins_req = 1'b0;
        modelReset();
        compareAll();
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ins_done", ins_done, 0);
        checkOutput("post_rst_occ", occupancy, 0);
        for (int t = 0; t < 5; t++) begin
            insertTag(32'h20 + t, 1'b1);
        end
        checkOutput("rst_ages_way", ins_way, 4'b0001);
        checkOutput("rst_ages_tag", evict_tag, 32'h20);

        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 1) == 1,
                          (32'(32'h30 + $urandom_range(0, 6)) << 5) | 32'($urandom_range(0, 31)),
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 1,
                          (32'(32'h30 + $urandom_range(0, 6)) << 5) | 32'($urandom_range(0, 31)),
                          $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
